// File: rtl/mult_wb_sched_if.sv
// Issue/writeback bundle between decode and the multiply/writeback scheduler.
interface mult_wb_sched_if #(
    parameter int REG_ADDR = 5
);
    logic                issue_valid;
    logic                issue_is_mult;
    logic                issue_regwrite;
    logic [REG_ADDR-1:0] issue_wreg;
    logic [REG_ADDR-1:0] issue_rs;
    logic [REG_ADDR-1:0] issue_rt;
    logic                issue_rs_used;
    logic                issue_rt_used;
    logic                issue_stall;
    logic                wb_valid;
    logic                wb_sel_mult;
    logic [REG_ADDR-1:0] wb_wreg;
    logic                mult_busy;

    modport master (
        output issue_valid, issue_is_mult, issue_regwrite, issue_wreg,
               issue_rs, issue_rt, issue_rs_used, issue_rt_used,
        input  issue_stall, wb_valid, wb_sel_mult, wb_wreg, mult_busy
    );

    modport slave (
        input  issue_valid, issue_is_mult, issue_regwrite, issue_wreg,
               issue_rs, issue_rt, issue_rs_used, issue_rt_used,
        output issue_stall, wb_valid, wb_sel_mult, wb_wreg, mult_busy
    );
endinterface

// File: rtl/mult_wb_sched.sv
// Issue scheduler for the multiply pipeline and the shared register-file write port.
// Entry d of the schedule describes the writeback that happens d cycles from now.
module mult_wb_sched #(
    parameter int MULT_LAT = 5,
    parameter int ALU_LAT  = 2,
    parameter int REG_ADDR = 5
) (
    input  logic           clk,
    input  logic           reset,
    mult_wb_sched_if.slave bus
);
    localparam logic [REG_ADDR-1:0] ZERO_REG = {REG_ADDR{1'b0}};

    logic [MULT_LAT-1:0] occ_q, occ_d;
    logic [MULT_LAT-1:0] ism_q, ism_d;
    logic [REG_ADDR-1:0] wreg_q [MULT_LAT];
    logic [REG_ADDR-1:0] wreg_d [MULT_LAT];
    logic                busy_q, busy_d;

    logic                collision_s;
    logic                raw_s;
    logic                waw_s;
    logic                accept_s;
    logic                load_s;
    int                  load_idx_s;
    logic [MULT_LAT-1:0] occ_sh_s, ism_sh_s;
    logic [REG_ADDR-1:0] wreg_sh_s [MULT_LAT];

    // Hazard detection against the current schedule; only multiply entries feed RAW/WAW.
    always_comb begin
        raw_s = 1'b0;
        waw_s = 1'b0;
        for (int d = 0; d < MULT_LAT; d++) begin
            raw_s = raw_s | (occ_q[d] & ism_q[d] &
                    ((bus.issue_rs_used & (bus.issue_rs != ZERO_REG) & (bus.issue_rs == wreg_q[d])) |
                     (bus.issue_rt_used & (bus.issue_rt != ZERO_REG) & (bus.issue_rt == wreg_q[d]))));
            waw_s = waw_s | (occ_q[d] & ism_q[d] & bus.issue_regwrite &
                    (bus.issue_wreg != ZERO_REG) & (bus.issue_wreg == wreg_q[d]));
        end
        collision_s = ~bus.issue_is_mult & bus.issue_regwrite & occ_q[ALU_LAT];
    end

    assign bus.issue_stall = bus.issue_valid & (collision_s | raw_s | waw_s);
    assign accept_s        = bus.issue_valid & ~bus.issue_stall;
    assign load_s          = accept_s & bus.issue_regwrite;
    assign load_idx_s      = bus.issue_is_mult ? (MULT_LAT - 1) : (ALU_LAT - 1);

    // Shift the schedule by one slot, then drop a newly accepted writer into its slot.
    // The load slot is always free after the shift: collisions stall and the top slot empties.
    always_comb begin
        occ_sh_s = {1'b0, occ_q[MULT_LAT-1:1]};
        ism_sh_s = {1'b0, ism_q[MULT_LAT-1:1]};
        for (int d = 0; d < MULT_LAT - 1; d++) begin
            wreg_sh_s[d] = wreg_q[d+1];
        end
        wreg_sh_s[MULT_LAT-1] = ZERO_REG;
        for (int d = 0; d < MULT_LAT; d++) begin
            occ_d[d]  = occ_sh_s[d] | (load_s & (load_idx_s == d));
            ism_d[d]  = (load_s && (load_idx_s == d)) ? bus.issue_is_mult : ism_sh_s[d];
            wreg_d[d] = (load_s && (load_idx_s == d)) ? bus.issue_wreg : wreg_sh_s[d];
        end
        busy_d = |(occ_d & ism_d);
    end

    // Schedule state; reset discards every in-flight op.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ_q  <= '0;
            ism_q  <= '0;
            busy_q <= 1'b0;
            for (int d = 0; d < MULT_LAT; d++) begin
                wreg_q[d] <= ZERO_REG;
            end
        end else begin
            occ_q  <= occ_d;
            ism_q  <= ism_d;
            busy_q <= busy_d;
            for (int d = 0; d < MULT_LAT; d++) begin
                wreg_q[d] <= wreg_d[d];
            end
        end
    end

    assign bus.wb_valid    = occ_q[0];
    assign bus.wb_sel_mult = ism_q[0];
    assign bus.wb_wreg     = wreg_q[0];
    assign bus.mult_busy   = busy_q;
endmodule

// File: tb/tb_mult_wb_sched.sv
// Directed bench for mult_wb_sched: latency, port collision, RAW, WAW, back-to-back and reset.
module tb_mult_wb_sched;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    mult_wb_sched_if #(.REG_ADDR(5)) bus_if ();

    mult_wb_sched #(.MULT_LAT(5), .ALU_LAT(2), .REG_ADDR(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input bit v, input bit m, input bit rw, input logic [4:0] wr,
                            input logic [4:0] rs, input logic [4:0] rt, input bit ru, input bit tu);
        bus_if.issue_valid    = v;
        bus_if.issue_is_mult  = m;
        bus_if.issue_regwrite = rw;
        bus_if.issue_wreg     = wr;
        bus_if.issue_rs       = rs;
        bus_if.issue_rt       = rt;
        bus_if.issue_rs_used  = ru;
        bus_if.issue_rt_used  = tu;
        #1;
    endtask

    task automatic idle();
        drive_op(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_wb_valid", 32'(bus_if.wb_valid), 32'd0);
        check_val("rst_busy", 32'(bus_if.mult_busy), 32'd0);
        check_val("rst_wreg", 32'(bus_if.wb_wreg), 32'd0);
        reset = 1'b0;

        // 1: single multiply r3
        step(); drive_op(1'b1, 1'b1, 1'b1, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0);
        check_val("t1_stall", 32'(bus_if.issue_stall), 32'd0);
        for (int c = 1; c <= 7; c++) begin
            step(); idle();
            check_val("t1_wb_valid", 32'(bus_if.wb_valid), 32'(c == 5));
            check_val("t1_busy", 32'(bus_if.mult_busy), 32'(c >= 1 && c <= 5));
            if (c == 5) begin
                check_val("t1_sel", 32'(bus_if.wb_sel_mult), 32'd1);
                check_val("t1_wreg", 32'(bus_if.wb_wreg), 32'd3);
            end
        end

        // 2: port collision
        step(); drive_op(1'b1, 1'b1, 1'b1, 5'd4, 5'd0, 5'd0, 1'b0, 1'b0);
        step(); idle();
        step(); idle();
        step(); drive_op(1'b1, 1'b0, 1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0);
        check_val("t2_stall_c3", 32'(bus_if.issue_stall), 32'd1);
        step(); drive_op(1'b1, 1'b0, 1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0);
        check_val("t2_stall_c4", 32'(bus_if.issue_stall), 32'd0);
        step(); idle();
        check_val("t2_wb5_valid", 32'(bus_if.wb_valid), 32'd1);
        check_val("t2_wb5_sel", 32'(bus_if.wb_sel_mult), 32'd1);
        check_val("t2_wb5_wreg", 32'(bus_if.wb_wreg), 32'd4);
        step(); idle();
        check_val("t2_wb6_valid", 32'(bus_if.wb_valid), 32'd1);
        check_val("t2_wb6_sel", 32'(bus_if.wb_sel_mult), 32'd0);
        check_val("t2_wb6_wreg", 32'(bus_if.wb_wreg), 32'd5);
        step(); idle();
        check_val("t2_wb7_valid", 32'(bus_if.wb_valid), 32'd0);

        // 3: RAW on multiply destination r7
        step(); drive_op(1'b1, 1'b1, 1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0);
        for (int c = 1; c <= 6; c++) begin
            step(); drive_op(1'b1, 1'b0, 1'b1, 5'd10, 5'd7, 5'd0, 1'b1, 1'b0);
            check_val("t3_raw_stall", 32'(bus_if.issue_stall), 32'(c <= 5));
        end
        step(); idle();
        step(); idle();
        check_val("t3_wb_valid", 32'(bus_if.wb_valid), 32'd1);
        check_val("t3_wb_wreg", 32'(bus_if.wb_wreg), 32'd10);
        check_val("t3_wb_sel", 32'(bus_if.wb_sel_mult), 32'd0);
        step(); drive_op(1'b1, 1'b1, 1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0);
        step(); drive_op(1'b1, 1'b0, 1'b1, 5'd10, 5'd0, 5'd0, 1'b1, 1'b0);
        check_val("t3_r0_stall", 32'(bus_if.issue_stall), 32'd0);
        repeat (6) begin step(); idle(); end

        // 4: WAW on r9, store slips through
        step(); drive_op(1'b1, 1'b1, 1'b1, 5'd9, 5'd0, 5'd0, 1'b0, 1'b0);
        for (int c = 1; c <= 6; c++) begin
            step();
            if (c == 3) begin
                drive_op(1'b1, 1'b0, 1'b0, 5'd9, 5'd0, 5'd0, 1'b0, 1'b0);
                check_val("t4_store_stall", 32'(bus_if.issue_stall), 32'd0);
            end else begin
                drive_op(1'b1, 1'b0, 1'b1, 5'd9, 5'd0, 5'd0, 1'b0, 1'b0);
                check_val("t4_waw_stall", 32'(bus_if.issue_stall), 32'(c <= 5));
            end
        end
        step(); idle();
        step(); idle();
        check_val("t4_wb_valid", 32'(bus_if.wb_valid), 32'd1);
        check_val("t4_wb_wreg", 32'(bus_if.wb_wreg), 32'd9);
        check_val("t4_wb_sel", 32'(bus_if.wb_sel_mult), 32'd0);
        step(); idle();

        // 5: back-to-back multiplies r1..r5
        for (int k = 0; k < 5; k++) begin
            step(); drive_op(1'b1, 1'b1, 1'b1, 5'(k + 1), 5'd0, 5'd0, 1'b0, 1'b0);
            check_val("t5_stall", 32'(bus_if.issue_stall), 32'd0);
        end
        for (int c = 5; c <= 10; c++) begin
            step(); idle();
            check_val("t5_wb_valid", 32'(bus_if.wb_valid), 32'(c <= 9));
            check_val("t5_busy", 32'(bus_if.mult_busy), 32'(c <= 9));
            if (c <= 9) begin
                check_val("t5_wb_wreg", 32'(bus_if.wb_wreg), 32'(c - 4));
                check_val("t5_wb_sel", 32'(bus_if.wb_sel_mult), 32'd1);
            end
        end

        // 6: reset with two multiplies in flight
        step(); drive_op(1'b1, 1'b1, 1'b1, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0);
        step(); drive_op(1'b1, 1'b1, 1'b1, 5'd2, 5'd0, 5'd0, 1'b0, 1'b0);
        step(); idle();
        check_val("t6_busy_pre", 32'(bus_if.mult_busy), 32'd1);
        reset = 1'b1;
        #1;
        check_val("t6_rst_valid", 32'(bus_if.wb_valid), 32'd0);
        check_val("t6_rst_sel", 32'(bus_if.wb_sel_mult), 32'd0);
        check_val("t6_rst_wreg", 32'(bus_if.wb_wreg), 32'd0);
        check_val("t6_rst_busy", 32'(bus_if.mult_busy), 32'd0);
        drive_op(1'b1, 1'b0, 1'b1, 5'd8, 5'd1, 5'd2, 1'b1, 1'b1);
        check_val("t6_rst_stall", 32'(bus_if.issue_stall), 32'd0);
        idle();
        step();
        reset = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            step(); idle();
            check_val("t6_no_wb", 32'(bus_if.wb_valid), 32'd0);
        end
        step(); drive_op(1'b1, 1'b1, 1'b1, 5'd6, 5'd2, 5'd1, 1'b1, 1'b1);
        check_val("t6_next_stall", 32'(bus_if.issue_stall), 32'd0);
        repeat (5) begin step(); idle(); end
        check_val("t6_next_wb", 32'(bus_if.wb_valid), 32'd1);
        check_val("t6_next_wreg", 32'(bus_if.wb_wreg), 32'd6);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
